// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// iteration counter width and the controller state encoding.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem,quo} left by one,
// trial-subtract the divisor and keep or restore the partial remainder.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           fits;

    // rem < divisor on entry, so the trial lies in [-divisor, divisor-1] and
    // WIDTH+1 signed bits are enough; its MSB is the borrow.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        trial    = shifted - {1'b0, divisor};
        fits     = ~trial[WIDTH];
        rem_next = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div32_seq.sv
// Iterative DIV/DIVU unit: one quotient bit per clock with a start/busy/done
// handshake; remainder feeds HI, quotient feeds LO.
module div32_seq
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem, step_quo;

    // The most-negative value maps to 2^(WIDTH-1), which is representable unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        return (sgn && v[WIDTH-1]) ? ('0 - v) : v;
    endfunction

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .divisor (dvsr_q),
        .rem_next(step_rem),
        .quo_next(step_quo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvsr_d    = magnitude(divisor, is_signed);
                    quo_d     = magnitude(dividend, is_signed);
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d = is_signed & dividend[WIDTH-1];
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                quotient_d  = neg_quo_q ? ('0 - quo_q) : quo_q;
                remainder_d = neg_rem_q ? ('0 - rem_q) : rem_q;
                dbz_d       = 1'b0;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy        = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign done        = (state_q == ST_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: expected results are queued when an
// operation is launched and popped when done is observed.
module tb_div32_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    div32_seq #(
        .WIDTH(32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    // Reference: truncating division, remainder sign follows the dividend.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic dbz);
        dbz = 1'b0;
        if (b == 32'd0) begin
            q   = 32'hFFFF_FFFF;
            r   = a;
            dbz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (s) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Launch one operation (start high in cycle 0) and follow it to done.
    // inj_cycle > 0 raises start again with other operands in that cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                          input int exp_lat, input int inj_cycle, input string name);
        exp_t e;
        int   lat;
        int   bad_hs;
        sb.push_back({eq, er, edbz});
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        lat       = 0;
        bad_hs    = 0;
        for (int c = 1; c <= exp_lat + 8 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 2) begin
                dividend = ~a;
                divisor  = b ^ 32'h0000_00F0;
            end
            if (c == inj_cycle) begin
                start     = 1'b1;
                dividend  = 32'd1234;
                divisor   = 32'd3;
                is_signed = ~s;
            end else if (inj_cycle != 0 && c == inj_cycle + 1) begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                lat = c;
                if (busy !== 1'b0) bad_hs++;
            end else if (busy !== (c < exp_lat)) begin
                bad_hs++;
            end
        end
        checks++;
        if (bad_hs != 0) begin
            failures++;
            $display("FAIL %s busy_profile: %0d bad cycles, required 0", name, bad_hs);
        end
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d (0=timeout), required %0d", name, lat, exp_lat);
        end
        e = sb.pop_front();
        if (lat != 0) begin
            checks++;
            if (quotient !== e.q) begin
                failures++;
                $display("FAIL %s quotient: got %h, required %h", name, quotient, e.q);
            end
            checks++;
            if (remainder !== e.r) begin
                failures++;
                $display("FAIL %s remainder: got %h, required %h", name, remainder, e.r);
            end
            checks++;
            if (div_by_zero !== e.dbz) begin
                failures++;
                $display("FAIL %s div_by_zero: got %b, required %b", name, div_by_zero, e.dbz);
            end
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done: done=%b busy=%b, required 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b dbz=%b q=%h r=%h, required all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_divu();
        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34, 0, "divu_100_7");
    endtask

    task automatic test_signed();
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 0, "div_m7_2");
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 34, 0, "div_7_m2");
    endtask

    task automatic test_div_by_zero();
        run_op(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 0, "divu_5_0");
        run_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 34, 0, "divu_9_3");
        run_op(32'hFFFF_FFF8, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 1'b1, 1, 0, "div_m8_0");
    endtask

    task automatic test_boundaries();
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 34, 0, "div_ovf");
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 34, 0, "divu_max_1");
    endtask

    task automatic test_ignored_start();
        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34, 10, "start_while_busy");
    endtask

    task automatic test_back_to_back();
        run_op(32'd200, 32'd9, 1'b0, 32'd22, 32'd2, 1'b0, 34, 34, "start_in_done");
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_in_done_ignored: busy=%b, required 0", busy);
        end
        run_op(32'd50, 32'd8, 1'b0, 32'd6, 32'd2, 1'b0, 34, 0, "next_idle_start");
    endtask

    task automatic test_reset_mid();
        int spurious;
        @(negedge clk);
        dividend  = 32'd100;
        divisor   = 32'd7;
        is_signed = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            failures++;
            $display("FAIL reset_mid_async: busy=%b done=%b dbz=%b q=%h r=%h, required all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("FAIL reset_mid_no_done: %0d active cycles, required 0", spurious);
        end
        run_op(32'd81, 32'd9, 1'b0, 32'd9, 32'd0, 1'b0, 34, 0, "divu_81_9");
    endtask

    task automatic test_random();
        logic [31:0] a, b, q, r;
        logic        s, dbz;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            s = 1'($urandom_range(0, 1));
            if (i == 3) b = 32'd0;
            model(a, b, s, q, r, dbz);
            run_op(a, b, s, q, r, dbz, (b == 32'd0) ? 1 : 34, 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_div_by_zero();
        test_boundaries();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
